adder_seq_ctrl: RTL and testbench

- Multi-byte add/subtract sequencer that sits directly upstream of the team's 8-bit ripple-carry adder.
- Accepts NBYTES-wide operands through a valid/ready handshake.
- Feeds the adder one byte per cycle, LSB first, chaining the adder's carry-out back in as carry-in for the next byte.
- Presents the full-width sum, carry and signed overflow through a valid/ready output handshake.

---
 rtl/adder_seq_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-byte add/subtract sequencer for an external 8-bit
// combinational ripple-carry adder. Operands are fed to the adder one byte per
// cycle, LSB first, and the adder's carry-out is fed back as the next byte's
// carry-in. The full-width result is presented through a valid/ready handshake.
// Optional feature macro: ADDSEQ_SAT_EN. When it is defined, a result with
// signed overflow saturates when it is captured.
module adder_seq_ctrl #(
    parameter int NBYTES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic                in_sub,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_sum,
    input  logic                add_cout,
    input  logic                add_ovf,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf,
    output logic                busy
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_idx;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_sub;
    logic              r_carry;
    logic [W-1:0]      r_res;
    logic              r_cout;
    logic              r_ovf;

    logic              w_accept;
    logic              w_last;
    logic [7:0]        w_a_byte;
    logic [7:0]        w_b_byte;
    logic [W-1:0]      w_res_next;
    logic [W-1:0]      w_res_cap;

    // in_ready is held low while rst is asserted, so nothing is accepted at a reset edge.
    assign in_ready  = (r_state == ST_IDLE) & ~rst;
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_idx == IDXW'(NBYTES - 1));
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN) | (r_state == ST_DONE);
    assign out_sum   = r_res;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

    // State register: synchronous reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last byte, DONE -> IDLE on handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Select the current operand bytes, and merge the adder's sum into the result at byte idx.
    always_comb begin
        w_a_byte   = 8'd0;
        w_b_byte   = 8'd0;
        w_res_next = r_res;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_byte              = r_a[i*8 +: 8];
                w_b_byte              = r_b[i*8 +: 8];
                w_res_next[i*8 +: 8]  = add_sum;
            end else begin
                w_a_byte              = w_a_byte;
                w_b_byte              = w_b_byte;
                w_res_next[i*8 +: 8]  = r_res[i*8 +: 8];
            end
        end
    end

    // Value written to the result register on a RUN edge (optionally saturated on the final byte).
    always_comb begin
        w_res_cap = w_res_next;
`ifdef ADDSEQ_SAT_EN
        if (w_last && add_ovf) begin
            if (r_a[W-1]) begin
                w_res_cap = {1'b1, {(W-1){1'b0}}};
            end else begin
                w_res_cap = {1'b0, {(W-1){1'b1}}};
            end
        end else begin
            w_res_cap = w_res_next;
        end
`else
        w_res_cap = w_res_next;
`endif
    end

    // Adder drive: the selected bytes in RUN (B inverted for subtract), zeros in all other states.
    always_comb begin
        add_a   = 8'd0;
        add_b   = 8'd0;
        add_cin = 1'b0;
        case (r_state)
            ST_RUN: begin
                add_a   = w_a_byte;
                add_b   = w_b_byte ^ {8{r_sub}};
                add_cin = r_carry;
            end
            ST_IDLE, ST_DONE: begin
                add_a   = 8'd0;
                add_b   = 8'd0;
                add_cin = 1'b0;
            end
            default: begin
                add_a   = 8'd0;
                add_b   = 8'd0;
                add_cin = 1'b0;
            end
        endcase
    end

    // Datapath registers: latch operands on accept, then capture one byte of the result per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_sub   <= in_sub;
                        r_idx   <= '0;
                        // For subtract, the initial carry-in of 1 completes the two's complement of B.
                        r_carry <= in_sub;
                    end
                end
                ST_RUN: begin
                    r_res   <= w_res_cap;
                    r_carry <= add_cout;
                    if (w_last) begin
                        r_cout <= add_cout;
                        r_ovf  <= add_ovf;
                    end else begin
                        r_idx  <= r_idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    r_res <= r_res;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed testbench for adder_seq_ctrl (NBYTES=2). A behavioural model of the
// 8-bit ripple-carry adder is connected to the add_* ports.
module tb_adder_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        add_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        busy;

    int n_checks;
    int n_pass;

    adder_seq_ctrl #(.NBYTES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .add_ovf   (add_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // 8-bit combinational adder model with signed overflow.
    always_comb begin
        {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
        add_ovf = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, let it be accepted at the next edge; returns in RUN pass 0.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
        chk("in_ready_before_req", {31'd0, in_ready}, 32'd1);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Check the DONE-state outputs.
    task automatic check_done(input string tag, input logic [15:0] s, input logic c, input logic v);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_sum"},   {16'd0, out_sum},   {16'd0, s});
        chk({tag, "_cout"},  {31'd0, out_cout},  {31'd0, c});
        chk({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, v});
    endtask

    // Complete the output handshake and check the return to IDLE.
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_hs_ready"}, {31'd0, in_ready},  32'd1);
    endtask

    logic [15:0] exp_sat_7fff;
    logic [15:0] exp_sat_8000;
    logic [15:0] held_sum;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'd0;
        in_b      = 16'd0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
`ifdef ADDSEQ_SAT_EN
        exp_sat_7fff = 16'h7FFF;
        exp_sat_8000 = 16'h8000;
`else
        exp_sat_7fff = 16'h8000;
        exp_sat_8000 = 16'h0000;
`endif

        // Reset state.
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready},  32'd0);
        chk("rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_sum",      {16'd0, out_sum},   32'd0);
        chk("rst_cout",     {31'd0, out_cout},  32'd0);
        chk("rst_ovf",      {31'd0, out_ovf},   32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Add with inter-byte carry: 0x00FF + 0x0001.
        start_op(16'h00FF, 16'h0001, 1'b0);
        chk("add_p0_a",    {24'd0, add_a},     32'hFF);
        chk("add_p0_b",    {24'd0, add_b},     32'h01);
        chk("add_p0_cin",  {31'd0, add_cin},   32'd0);
        chk("add_p0_busy", {31'd0, busy},      32'd1);
        chk("add_p0_rdy",  {31'd0, in_ready},  32'd0);
        chk("add_p0_vld",  {31'd0, out_valid}, 32'd0);
        step();
        chk("add_p1_cin",  {31'd0, add_cin},   32'd1);
        chk("add_p1_a",    {24'd0, add_a},     32'h00);
        chk("add_p1_vld",  {31'd0, out_valid}, 32'd0);
        step();
        check_done("add", 16'h0100, 1'b0, 1'b0);
        chk("add_done_adda", {24'd0, add_a},   32'd0);
        chk("add_done_cin",  {31'd0, add_cin}, 32'd0);
        handshake("add");

        // Subtract with borrow: 0x0000 - 0x0001.
        start_op(16'h0000, 16'h0001, 1'b1);
        chk("sub_p0_b",   {24'd0, add_b},   32'hFE);
        chk("sub_p0_cin", {31'd0, add_cin}, 32'd1);
        step();
        chk("sub_p1_b",   {24'd0, add_b},   32'hFF);
        step();
        check_done("sub", 16'hFFFF, 1'b0, 1'b0);
        handshake("sub");

        // Signed overflow: 0x7FFF + 0x0001.
        start_op(16'h7FFF, 16'h0001, 1'b0);
        step();
        step();
        check_done("ovf1", exp_sat_7fff, 1'b0, 1'b1);
        handshake("ovf1");

        // Signed overflow with carry: 0x8000 + 0x8000, then backpressure in DONE.
        start_op(16'h8000, 16'h8000, 1'b0);
        step();
        step();
        check_done("ovf2", exp_sat_8000, 1'b1, 1'b1);
        held_sum = out_sum;
        in_a     = 16'h5555;
        in_b     = 16'h1111;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum",   {16'd0, out_sum},   {16'd0, exp_sat_8000});
            chk("bp_ready", {31'd0, in_ready},  32'd0);
        end
        chk("bp_sum_stable", {16'd0, out_sum}, {16'd0, held_sum});
        in_valid = 1'b0;
        handshake("bp");

        // Next request after backpressure, with out_ready held high throughout.
        out_ready = 1'b1;
        start_op(16'h1234, 16'h1111, 1'b0);
        chk("rdy_idle_busy", {31'd0, busy}, 32'd1);
        step();
        chk("rdy_p1_vld", {31'd0, out_valid}, 32'd0);
        step();
        check_done("nxt", 16'h2345, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        chk("nxt_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("nxt_hs_ready", {31'd0, in_ready},  32'd1);

        // Reset mid-operation after pass 0.
        start_op(16'h0F0F, 16'h0101, 1'b0);
        rst = 1'b1;
        step();
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_sum",   {16'd0, out_sum},   32'd0);
        chk("mrst_busy",  {31'd0, busy},      32'd0);
        chk("mrst_ready", {31'd0, in_ready},  32'd0);
        rst = 1'b0;
        step();
        chk("mrst_ready_after", {31'd0, in_ready},  32'd1);
        chk("mrst_valid_after", {31'd0, out_valid}, 32'd0);
        start_op(16'h0001, 16'h0001, 1'b1);
        step();
        step();
        check_done("sub0", 16'h0000, 1'b1, 1'b0);
        handshake("sub0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
